sobel_stream: RTL and testbench

Parametrised streaming 3x3 edge-detection engine that replaces the frame-buffered window-read plus Sobel stage between the grayscale converter and the VGA output path. It accepts raster-order grayscale pixels over a valid/ready stream, builds the 3x3 window internally from two line buffers, and emits one edge pixel per input pixel, also in raster order. It adds runtime frame size, four output modes, a binary threshold, full backpressure, and end-of-frame signalling.

---
 rtl/sobel_pkg.sv | 17 +
 rtl/line_buffer.sv | 25 ++
 rtl/sobel_stream.sv | 178 +++++++++++++++++
 tb/tb_sobel_stream.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and arithmetic helpers for the streaming Sobel engine.
package sobel_pkg;

  typedef enum logic [1:0] {GRAD_SUM, GRAD_X, GRAD_Y, THRESH} mode_t;
  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  function automatic int unsigned abs_s(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int unsigned sat_u(input int unsigned v, input int unsigned w);
    int unsigned lim;
    lim = (32'd1 << w) - 32'd1;
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-port line store: synchronous read, read-before-write at the shared address.
module line_buffer #(
  parameter int DEPTH  = 640,
  parameter int DATA_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_en,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_rdata        <= r_mem[i_addr];
      r_mem[i_addr]  <= i_wdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: raster pixels in, one edge pixel out per input,
// with runtime frame size, four output modes and full valid/ready backpressure.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int MAX_W = 640,
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] threshold,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             m_last,
  output logic             cfg_err,
  output logic             frame_done
);

  localparam int GW = PIX_W + 3;
  localparam int AW = $clog2(MAX_W);

  state_t           r_state, w_state_nxt;
  mode_t            r_mode;
  logic [DIM_W-1:0] r_width, r_height, r_icol, r_irow, r_ocol, r_orow;
  logic [PIX_W-1:0] r_thresh;
  logic [AW-1:0]    r_ptr, w_ptr_last;
  logic [PIX_W-1:0] r_top [2], r_mid [2], r_bot [2];
  logic [PIX_W-1:0] w_lb0_q, w_lb1_q;
  logic             r_m_valid, r_m_last, r_frame_done;
  logic [PIX_W-1:0] r_m_data;

  logic w_cfg_ok, w_advance, w_s_ready, w_s_fire, w_in_last, w_out_last;
  logic w_last_held, w_produce, w_done, w_border;
  logic [PIX_W-1:0]       w_p [9];
  logic signed [GW-1:0]   w_gx, w_gy;
  int unsigned            w_mag_x, w_mag_y, w_sum;
  logic [31:0]            w_thr32;
  logic [PIX_W-1:0]       w_grad, w_pix;

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return signed'(GW'(p));
  endfunction

  assign w_cfg_ok    = (width >= DIM_W'(3)) && (width <= DIM_W'(MAX_W)) && (height >= DIM_W'(3));
  assign w_advance   = !r_m_valid || m_ready;
  assign w_s_ready   = rstn && w_advance && (r_state != FLUSH) && ((r_state != IDLE) || w_cfg_ok);
  assign w_s_fire    = s_valid && w_s_ready;
  assign w_in_last   = (r_irow == r_height - 1'b1) && (r_icol == r_width - 1'b1);
  assign w_out_last  = (r_orow == r_height - 1'b1) && (r_ocol == r_width - 1'b1);
  assign w_last_held = r_m_valid && r_m_last;
  assign w_produce   = ((r_state == RUN) && w_s_fire) ||
                       ((r_state == FLUSH) && w_advance && !w_last_held);
  assign w_done      = (r_state == FLUSH) && w_last_held && m_ready;
  assign w_border    = (r_orow == '0) || (r_orow == r_height - 1'b1) ||
                       (r_ocol == '0) || (r_ocol == r_width - 1'b1);

  // Line-buffer pointer cycles over width-1 slots: with the registered read this
  // gives exactly width accepts of delay, so the rows above line up with s_data.
  assign w_ptr_last = AW'(r_width - DIM_W'(2));

  line_buffer #(.DEPTH(MAX_W), .DATA_W(PIX_W)) u_lb0 (
    .i_clk(clk), .i_en(w_s_fire), .i_addr(r_ptr), .i_wdata(s_data), .o_rdata(w_lb0_q)
  );
  line_buffer #(.DEPTH(MAX_W), .DATA_W(PIX_W)) u_lb1 (
    .i_clk(clk), .i_en(w_s_fire), .i_addr(r_ptr), .i_wdata(w_lb0_q), .o_rdata(w_lb1_q)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_s_fire) w_state_nxt = FILL;
      FILL:    if (w_s_fire && (r_irow == DIM_W'(1)) && (r_icol == '0)) w_state_nxt = RUN;
      RUN:     if (w_s_fire && w_in_last) w_state_nxt = FLUSH;
      FLUSH:   if (w_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_p[0] = r_top[0]; w_p[1] = r_top[1]; w_p[2] = w_lb1_q;
    w_p[3] = r_mid[0]; w_p[4] = r_mid[1]; w_p[5] = w_lb0_q;
    w_p[6] = r_bot[0]; w_p[7] = r_bot[1]; w_p[8] = s_data;
    w_gx = (ext(w_p[2]) + (ext(w_p[5]) <<< 1) + ext(w_p[8])) -
           (ext(w_p[0]) + (ext(w_p[3]) <<< 1) + ext(w_p[6]));
    w_gy = (ext(w_p[6]) + (ext(w_p[7]) <<< 1) + ext(w_p[8])) -
           (ext(w_p[0]) + (ext(w_p[1]) <<< 1) + ext(w_p[2]));
    w_mag_x = abs_s(int'(w_gx));
    w_mag_y = abs_s(int'(w_gy));
    w_sum   = w_mag_x + w_mag_y;
    w_thr32 = 32'(r_thresh);
    w_grad  = '0;
    case (r_mode)
      GRAD_SUM: w_grad = PIX_W'(sat_u(w_sum, PIX_W));
      GRAD_X:   w_grad = PIX_W'(sat_u(w_mag_x, PIX_W));
      GRAD_Y:   w_grad = PIX_W'(sat_u(w_mag_y, PIX_W));
      THRESH:   w_grad = (w_sum > w_thr32) ? '1 : '0;
      default:  w_grad = '0;
    endcase
    w_pix = w_border ? '0 : w_grad;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_width  <= '0; r_height <= '0; r_mode <= GRAD_SUM; r_thresh <= '0;
      r_icol   <= '0; r_irow   <= '0; r_ocol <= '0;       r_orow   <= '0;
      r_ptr    <= '0;
      r_top    <= '{default: '0}; r_mid <= '{default: '0}; r_bot <= '{default: '0};
    end else begin
      if (w_s_fire) begin
        r_top[0] <= r_top[1]; r_top[1] <= w_lb1_q;
        r_mid[0] <= r_mid[1]; r_mid[1] <= w_lb0_q;
        r_bot[0] <= r_bot[1]; r_bot[1] <= s_data;
        if (r_state == IDLE) begin
          r_width  <= width;  r_height <= height;
          r_mode   <= mode_t'(mode);
          r_thresh <= threshold;
          r_icol   <= DIM_W'(1); r_irow <= '0;
          r_ocol   <= '0;        r_orow <= '0;
          r_ptr    <= AW'(1);
        end else begin
          if (r_icol == r_width - 1'b1) begin
            r_icol <= '0;
            r_irow <= r_irow + 1'b1;
          end else begin
            r_icol <= r_icol + 1'b1;
          end
          r_ptr <= (r_ptr == w_ptr_last) ? '0 : r_ptr + 1'b1;
        end
      end
      if (w_produce) begin
        if (r_ocol == r_width - 1'b1) begin
          r_ocol <= '0;
          r_orow <= r_orow + 1'b1;
        end else begin
          r_ocol <= r_ocol + 1'b1;
        end
      end
      if (w_done) r_ptr <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_last     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_done;
      if (w_advance) begin
        r_m_valid <= w_produce;
        r_m_last  <= w_produce && w_out_last;
        if (w_produce) r_m_data <= w_pix;
      end
    end
  end

  assign s_ready    = w_s_ready;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_last     = r_m_last;
  assign frame_done = r_frame_done;
  assign cfg_err    = rstn && (r_state == IDLE) && !w_cfg_ok;

endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream: random/directed frames against a 2-D Sobel model.
module tb_sobel_stream;

  localparam int PIX_W = 8;
  localparam int MAX_W = 640;
  localparam int DIM_W = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic [DIM_W-1:0] width, height;
  logic [1:0]       mode;
  logic [PIX_W-1:0] threshold;
  logic             s_valid, s_ready, m_valid, m_ready, m_last, cfg_err, frame_done;
  logic [PIX_W-1:0] s_data, m_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int img [0:2047];
  int got [$];
  int got_ref [$];

  sobel_stream #(.PIX_W(PIX_W), .MAX_W(MAX_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rstn(rstn), .width(width), .height(height), .mode(mode),
    .threshold(threshold), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .cfg_err(cfg_err), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int kind, input int fw, input int fh);
    for (int r = 0; r < fh; r++)
      for (int c = 0; c < fw; c++)
        case (kind)
          0: img[r*fw+c] = 100;
          1: img[r*fw+c] = (c >= 2) ? 255 : 0;
          2: img[r*fw+c] = (c == 2) ? 60 : 0;
          3: img[r*fw+c] = (r*37 + c*29) & 255;
          default: img[r*fw+c] = $urandom_range(0, 255);
        endcase
  endtask

  function automatic int px(input int fw, input int r, input int c);
    return img[r*fw + c];
  endfunction

  function automatic int ref_pix(input int fw, input int fh, input int fm, input int fthr, input int k);
    int r, c, gx, gy, ax, ay;
    r = k / fw;
    c = k % fw;
    if (r == 0 || r == fh-1 || c == 0 || c == fw-1) return 0;
    gx = (px(fw,r-1,c+1) + 2*px(fw,r,c+1) + px(fw,r+1,c+1))
       - (px(fw,r-1,c-1) + 2*px(fw,r,c-1) + px(fw,r+1,c-1));
    gy = (px(fw,r+1,c-1) + 2*px(fw,r+1,c) + px(fw,r+1,c+1))
       - (px(fw,r-1,c-1) + 2*px(fw,r-1,c) + px(fw,r-1,c+1));
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    case (fm)
      0: return (ax+ay > 255) ? 255 : ax+ay;
      1: return (ax > 255) ? 255 : ax;
      2: return (ay > 255) ? 255 : ay;
      default: return (ax+ay > fthr) ? 255 : 0;
    endcase
  endfunction

  // Streams one frame; abort_at > 0 resets the DUT after that many accepted pixels.
  task automatic run_frame(input int fw, input int fh, input int fm, input int fthr,
                           input int vpct, input int rpct, input int abort_at);
    int n, in_idx, out_idx, first_cyc, budget;
    bit seen_valid, expect_done, done_seen, prev_stall, prev_last;
    int prev_data;
    n = fw*fh; in_idx = 0; out_idx = 0; first_cyc = -1; budget = 8*n + 200;
    seen_valid = 0; expect_done = 0; done_seen = 0; prev_stall = 0; prev_last = 0; prev_data = 0;
    got.delete();
    @(negedge clk);
    width = DIM_W'(fw); height = DIM_W'(fh); mode = 2'(fm); threshold = PIX_W'(fthr);
    while (!done_seen) begin
      if (budget == 0) begin
        chk("timeout", 0, 1);
        break;
      end
      budget--;
      @(negedge clk);
      s_valid = (in_idx < n) && ($urandom_range(0, 99) < vpct);
      s_data  = (in_idx < n) ? PIX_W'(img[in_idx]) : '0;
      m_ready = ($urandom_range(0, 99) < rpct);
      if (in_idx > 0) begin
        width = DIM_W'($urandom); height = DIM_W'($urandom);
        mode = 2'($urandom); threshold = PIX_W'($urandom);
      end
      #1;
      chk("frame_done", frame_done, expect_done);
      if (frame_done && expect_done) done_seen = 1;
      expect_done = 0;
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
        chk("stall_last", m_last, prev_last);
      end
      if (m_valid && !m_ready) chk("stall_sready", s_ready, 0);
      if (m_valid && !seen_valid) begin
        seen_valid = 1;
        chk("first_latency", cyc, first_cyc + 1);
      end
      if (s_valid && s_ready) begin
        if (in_idx == fw + 1) first_cyc = cyc;
        in_idx++;
      end
      if (m_valid && m_ready) begin
        chk("m_data", m_data, ref_pix(fw, fh, fm, fthr, out_idx));
        chk("m_last", m_last, (out_idx == n-1));
        got.push_back(int'(m_data));
        if (out_idx == n-1) expect_done = 1;
        out_idx++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = int'(m_data);
      prev_last  = m_last;
      if (abort_at > 0 && in_idx == abort_at) begin
        @(posedge clk);
        s_valid = 0;
        #2 rstn = 0;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_last", m_last, 0);
        repeat (2) @(negedge clk);
        rstn = 1;
        return;
      end
    end
    chk("out_count", out_idx, n);
    s_valid = 0;
    m_ready = 1;
    @(negedge clk);
    #1;
    chk("idle_valid", m_valid, 0);
    chk("idle_done", frame_done, 0);
  endtask

  task automatic bad_cfg(input int fw, input int fh);
    @(negedge clk);
    width = DIM_W'(fw); height = DIM_W'(fh); s_valid = 1; s_data = 8'd50; m_ready = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("cfg_err", cfg_err, 1);
    chk("cfg_s_ready", s_ready, 0);
    chk("cfg_m_valid", m_valid, 0);
    s_valid = 0;
  endtask

  initial begin
    rstn = 1; s_valid = 0; s_data = '0; m_ready = 0;
    width = 16'd4; height = 16'd4; mode = 2'd0; threshold = '0;
    #2 rstn = 0;
    #1;
    chk("reset_m_valid", m_valid, 0);
    chk("reset_s_ready", s_ready, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_m_last", m_last, 0);
    chk("reset_done", frame_done, 0);
    chk("reset_cfg_err", cfg_err, 0);
    repeat (2) @(negedge clk);
    rstn = 1;

    fill(0, 4, 4);
    run_frame(4, 4, 0, 0, 100, 100, 0);
    chk("flat_count", got.size(), 16);

    fill(1, 5, 5);
    run_frame(5, 5, 1, 0, 100, 100, 0);
    chk("vedge_c1", got[6], 255);
    chk("vedge_c2", got[7], 255);
    chk("vedge_c3", got[8], 0);
    run_frame(5, 5, 2, 0, 80, 70, 0);
    chk("vedge_gy", got[12], 0);

    fill(2, 3, 3);
    run_frame(3, 3, 3, 200, 100, 100, 0);
    chk("thr200_centre", got[4], 255);
    run_frame(3, 3, 3, 250, 100, 100, 0);
    chk("thr250_centre", got[4], 0);

    fill(3, 8, 6);
    run_frame(8, 6, 0, 0, 100, 100, 0);
    got_ref = got;
    run_frame(8, 6, 0, 0, 70, 50, 0);
    chk("bp_size", got.size(), got_ref.size());
    for (int i = 0; i < got_ref.size() && i < got.size(); i++) chk("bp_seq", got[i], got_ref[i]);

    for (int m = 0; m < 4; m++) begin
      fill(4, 7, 5);
      run_frame(7, 5, m, $urandom_range(0, 255), 75, 60, 0);
    end

    bad_cfg(2, 4);
    bad_cfg(MAX_W + 1, 4);
    bad_cfg(6, 2);

    fill(4, MAX_W, 3);
    run_frame(MAX_W, 3, 0, 0, 100, 100, 0);
    chk("maxw_count", got.size(), 3*MAX_W);

    fill(3, 6, 6);
    run_frame(6, 6, 0, 0, 100, 100, 10);
    fill(4, 6, 6);
    run_frame(6, 6, 0, 0, 90, 80, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
